// File: rtl/pipe_ctrl_unit_pkg.sv
// pipe_ctrl_unit_pkg
// Shared definitions for the ID-stage control unit:
//   - instruction_def : opcode and funct encodings understood by the decoder
//   - ctrl_encode_def : ALU op, immediate-extension and instruction-class codes
//   - ctrl_bundle_t   : the control bundle registered from ID into EX
//   - helpers         : bubble constructor and R-type funct -> ALU op mapping
package pipe_ctrl_unit_pkg;

  // ---------------- instruction_def ----------------
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  // ---------------- ctrl_encode_def ----------------
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_NOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_LUI  = 4'd6;

  localparam logic [1:0] EXT_ZERO  = 2'd0;
  localparam logic [1:0] EXT_SIGN  = 2'd1;
  localparam logic [1:0] EXT_UPPER = 2'd2;

  localparam logic [3:0] ID_RTYPE = 4'd0;
  localparam logic [3:0] ID_LW    = 4'd1;
  localparam logic [3:0] ID_SW    = 4'd2;
  localparam logic [3:0] ID_BEQ   = 4'd3;
  localparam logic [3:0] ID_BNE   = 4'd4;
  localparam logic [3:0] ID_J     = 4'd5;
  localparam logic [3:0] ID_JAL   = 4'd6;
  localparam logic [3:0] ID_IMM   = 4'd7;
  localparam logic [3:0] ID_MD    = 4'd8;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  localparam int MD_CNT_W = 4;

  typedef struct packed {
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic       link;
    logic [3:0] alu_op;
    logic [1:0] ext_op;
    logic [3:0] ins_id;
    logic [4:0] wr_addr;
    logic       md_start;
  } ctrl_bundle_t;

  // All controls inactive; the ALU op rests at ADD.
  function automatic ctrl_bundle_t ctrl_bubble();
    ctrl_bundle_t b;
    b        = '0;
    b.alu_op = ALU_ADD;
    return b;
  endfunction

  function automatic logic [3:0] alu_of_funct(input logic [5:0] funct);
    logic [3:0] r;
    case (funct)
      FN_ADD:  r = ALU_ADD;
      FN_SUB:  r = ALU_SUB;
      FN_AND:  r = ALU_AND;
      FN_OR:   r = ALU_OR;
      FN_NOR:  r = ALU_NOR;
      FN_SLT:  r = ALU_SLT;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_ctrl_decode.sv
// ctrl_decode
// Purely combinational decoder: instruction word -> control bundle,
// register-source usage flags, multiply-class flag and illegal flag.
// Ports:
//   ins     in  32  instruction in ID
//   bundle  out     decoded control bundle (bubble when illegal)
//   use_rs  out  1  instruction reads rs
//   use_rt  out  1  instruction reads rt
//   is_md   out  1  MULT / MFHI / MFLO (only when ENABLE_MD)
//   illegal out  1  encoding not recognised
module ctrl_decode
  import pipe_ctrl_unit_pkg::*;
#(
  parameter bit ENABLE_MD = 1'b1
) (
  input  logic [31:0]  ins,
  output ctrl_bundle_t bundle,
  output logic         use_rs,
  output logic         use_rt,
  output logic         is_md,
  output logic         illegal
);

  logic [5:0] opcode_s;
  logic [5:0] funct_s;
  logic [4:0] rt_s;
  logic [4:0] rd_s;
  logic       unused_shamt_s;

  assign opcode_s       = ins[31:26];
  assign funct_s        = ins[5:0];
  assign rt_s           = ins[20:16];
  assign rd_s           = ins[15:11];
  assign unused_shamt_s = ^ins[10:6];

  // Instruction decode into control bundle and source-usage flags.
  always_comb begin
    bundle  = ctrl_bubble();
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    is_md   = 1'b0;
    illegal = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT: begin
            bundle.reg_write = 1'b1;
            bundle.alu_op    = alu_of_funct(funct_s);
            bundle.ins_id    = ID_RTYPE;
            bundle.wr_addr   = rd_s;
            use_rs           = 1'b1;
            use_rt           = 1'b1;
          end
          FN_MULT: begin
            if (ENABLE_MD) begin
              bundle.md_start = 1'b1;
              bundle.ins_id   = ID_MD;
              use_rs          = 1'b1;
              use_rt          = 1'b1;
              is_md           = 1'b1;
            end else begin
              illegal = 1'b1;
            end
          end
          FN_MFHI, FN_MFLO: begin
            if (ENABLE_MD) begin
              bundle.reg_write = 1'b1;
              bundle.ins_id    = ID_MD;
              bundle.wr_addr   = rd_s;
              is_md            = 1'b1;
            end else begin
              illegal = 1'b1;
            end
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_LW: begin
        bundle.mem_to_reg = 1'b1;
        bundle.reg_write  = 1'b1;
        bundle.alu_src    = 1'b1;
        bundle.ext_op     = EXT_SIGN;
        bundle.ins_id     = ID_LW;
        bundle.wr_addr    = rt_s;
        use_rs            = 1'b1;
      end
      OP_SW: begin
        bundle.mem_write = 1'b1;
        bundle.alu_src   = 1'b1;
        bundle.ext_op    = EXT_SIGN;
        bundle.ins_id    = ID_SW;
        use_rs           = 1'b1;
        use_rt           = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        bundle.branch    = 1'b1;
        bundle.branch_ne = (opcode_s == OP_BNE);
        bundle.alu_op    = ALU_SUB;
        bundle.ext_op    = EXT_SIGN;
        bundle.ins_id    = (opcode_s == OP_BNE) ? ID_BNE : ID_BEQ;
        use_rs           = 1'b1;
        use_rt           = 1'b1;
      end
      OP_J: begin
        bundle.jump   = 1'b1;
        bundle.ins_id = ID_J;
      end
      OP_JAL: begin
        bundle.jump      = 1'b1;
        bundle.link      = 1'b1;
        bundle.reg_write = 1'b1;
        bundle.ins_id    = ID_JAL;
        bundle.wr_addr   = REG_RA;
      end
      OP_ADDI, OP_ORI: begin
        bundle.reg_write = 1'b1;
        bundle.alu_src   = 1'b1;
        bundle.alu_op    = (opcode_s == OP_ORI) ? ALU_OR : ALU_ADD;
        bundle.ext_op    = (opcode_s == OP_ORI) ? EXT_ZERO : EXT_SIGN;
        bundle.ins_id    = ID_IMM;
        bundle.wr_addr   = rt_s;
        use_rs           = 1'b1;
      end
      OP_LUI: begin
        bundle.reg_write = 1'b1;
        bundle.alu_src   = 1'b1;
        bundle.alu_op    = ALU_LUI;
        bundle.ext_op    = EXT_UPPER;
        bundle.ins_id    = ID_IMM;
        bundle.wr_addr   = rt_s;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit
// Registered ID->EX control stage: decodes the ID instruction, detects
// load-use and multiply-busy hazards, and registers the control bundle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ins, ins_valid      ID-stage instruction and its valid flag
//   ext_stall, flush    memory stall (hold all), taken branch (kill EX)
//   stall_if            combinational hold for PC and IF/ID
//   ex_*                registered EX control bundle
//   md_busy             multiply latency counter non-zero
//   illegal             one-cycle pulse for an issued unknown encoding
module pipe_ctrl_unit
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int ALUOP_W   = 4,
  parameter int INSID_W   = 4,
  parameter bit ENABLE_MD = 1'b1,
  parameter int MD_LAT    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        ins,
  input  logic               ins_valid,
  input  logic               ext_stall,
  input  logic               flush,
  output logic               stall_if,
  output logic               ex_valid,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg,
  output logic               ex_reg_write,
  output logic               ex_alu_src,
  output logic               ex_branch,
  output logic               ex_branch_ne,
  output logic               ex_jump,
  output logic               ex_link,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [1:0]         ex_ext_op,
  output logic [INSID_W-1:0] ex_ins_id,
  output logic [4:0]         ex_wr_addr,
  output logic               ex_md_start,
  output logic               md_busy,
  output logic               illegal
);

  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LAT);

  ctrl_bundle_t          dec_s;
  logic                  use_rs_s;
  logic                  use_rt_s;
  logic                  is_md_s;
  logic                  dec_illegal_s;
  logic [4:0]            rs_s;
  logic [4:0]            rt_s;
  logic                  load_use_s;
  logic                  md_haz_s;

  ctrl_bundle_t          ex_r;
  ctrl_bundle_t          ex_nxt_s;
  logic                  ex_valid_r;
  logic                  ex_valid_nxt_s;
  logic                  illegal_r;
  logic                  illegal_nxt_s;
  logic                  mult_issue_s;
  logic [MD_CNT_W-1:0]   md_cnt_r;
  logic [MD_CNT_W-1:0]   md_cnt_nxt_s;
  logic                  md_busy_r;

  assign rs_s = ins[25:21];
  assign rt_s = ins[20:16];

  ctrl_decode #(
    .ENABLE_MD (ENABLE_MD)
  ) u_decode (
    .ins     (ins),
    .bundle  (dec_s),
    .use_rs  (use_rs_s),
    .use_rt  (use_rt_s),
    .is_md   (is_md_s),
    .illegal (dec_illegal_s)
  );

  // Hazard detection against the load currently in EX and the MULT unit.
  always_comb begin
    if (ins_valid && ex_valid_r && ex_r.mem_to_reg && (ex_r.wr_addr != REG_ZERO)) begin
      load_use_s = (use_rs_s && (rs_s == ex_r.wr_addr)) ||
                   (use_rt_s && (rt_s == ex_r.wr_addr));
    end else begin
      load_use_s = 1'b0;
    end
    md_haz_s = ins_valid && md_busy_r && is_md_s;
  end

  assign stall_if = ext_stall | load_use_s | md_haz_s;

  // Next EX entry: flush beats stall-hold beats hazard bubble beats issue.
  always_comb begin
    ex_nxt_s       = ctrl_bubble();
    ex_valid_nxt_s = 1'b0;
    illegal_nxt_s  = 1'b0;
    mult_issue_s   = 1'b0;
    if (flush) begin
      ex_nxt_s = ctrl_bubble();
    end else if (ext_stall) begin
      // Held entry must not restart the multiplier a second time.
      ex_nxt_s          = ex_r;
      ex_nxt_s.md_start = 1'b0;
      ex_valid_nxt_s    = ex_valid_r;
    end else if (load_use_s || md_haz_s) begin
      ex_nxt_s = ctrl_bubble();
    end else if (ins_valid && !dec_illegal_s) begin
      ex_nxt_s       = dec_s;
      ex_valid_nxt_s = 1'b1;
      mult_issue_s   = dec_s.md_start;
    end else if (ins_valid) begin
      illegal_nxt_s = 1'b1;
    end else begin
      ex_nxt_s = ctrl_bubble();
    end
  end

  // Multiply latency counter: reload on issue, otherwise drain to zero.
  always_comb begin
    if (mult_issue_s) begin
      md_cnt_nxt_s = MD_LOAD;
    end else if (md_cnt_r != {MD_CNT_W{1'b0}}) begin
      md_cnt_nxt_s = md_cnt_r - {{(MD_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      md_cnt_nxt_s = md_cnt_r;
    end
  end

  // EX register, illegal pulse and multiply counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_r       <= ctrl_bubble();
      ex_valid_r <= 1'b0;
      illegal_r  <= 1'b0;
      md_cnt_r   <= {MD_CNT_W{1'b0}};
      md_busy_r  <= 1'b0;
    end else begin
      ex_r       <= ex_nxt_s;
      ex_valid_r <= ex_valid_nxt_s;
      illegal_r  <= illegal_nxt_s;
      md_cnt_r   <= md_cnt_nxt_s;
      md_busy_r  <= (md_cnt_nxt_s != {MD_CNT_W{1'b0}});
    end
  end

  assign ex_valid      = ex_valid_r;
  assign ex_mem_write  = ex_r.mem_write;
  assign ex_mem_to_reg = ex_r.mem_to_reg;
  assign ex_reg_write  = ex_r.reg_write;
  assign ex_alu_src    = ex_r.alu_src;
  assign ex_branch     = ex_r.branch;
  assign ex_branch_ne  = ex_r.branch_ne;
  assign ex_jump       = ex_r.jump;
  assign ex_link       = ex_r.link;
  assign ex_alu_op     = ALUOP_W'(ex_r.alu_op);
  assign ex_ext_op     = ex_r.ext_op;
  assign ex_ins_id     = INSID_W'(ex_r.ins_id);
  assign ex_wr_addr    = ex_r.wr_addr;
  assign ex_md_start   = ex_r.md_start;
  assign md_busy       = md_busy_r;
  assign illegal       = illegal_r;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit
// Self-checking bench: directed scenarios plus randomized instruction
// streams, all compared against a mnemonic-level reference model.
module tb_pipe_ctrl_unit;
  import pipe_ctrl_unit_pkg::*;

  localparam int MD_LAT = 4;

  // Mnemonic indices used by the reference model.
  localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_OR = 3, K_NOR = 4, K_SLT = 5;
  localparam int K_MULT = 6, K_MFHI = 7, K_MFLO = 8, K_LW = 9, K_SW = 10;
  localparam int K_BEQ = 11, K_BNE = 12, K_J = 13, K_JAL = 14, K_ADDI = 15;
  localparam int K_ORI = 16, K_LUI = 17, K_BAD = -1;

  typedef struct packed {
    logic       valid, mw, m2r, rw, asrc, br, bne, jmp, lnk;
    logic [3:0] alu;
    logic [1:0] ext;
    logic [3:0] id;
    logic [4:0] wr;
    logic       mds;
  } ex_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ins = 32'h0;
  logic        ins_valid = 1'b0, ext_stall = 1'b0, flush = 1'b0;

  logic       stall_if, ex_valid, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_alu_src;
  logic       ex_branch, ex_branch_ne, ex_jump, ex_link, ex_md_start, md_busy, illegal;
  logic [3:0] ex_alu_op, ex_ins_id;
  logic [1:0] ex_ext_op;
  logic [4:0] ex_wr_addr;

  logic       b_stall_if, b_ex_valid, b_ex_mem_write, b_ex_mem_to_reg, b_ex_reg_write, b_ex_alu_src;
  logic       b_ex_branch, b_ex_branch_ne, b_ex_jump, b_ex_link, b_ex_md_start, b_md_busy, b_illegal;
  logic [3:0] b_ex_alu_op, b_ex_ins_id;
  logic [1:0] b_ex_ext_op;
  logic [4:0] b_ex_wr_addr;

  pipe_ctrl_unit #(.ALUOP_W(4), .INSID_W(4), .ENABLE_MD(1'b1), .MD_LAT(MD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .ins(ins), .ins_valid(ins_valid), .ext_stall(ext_stall),
    .flush(flush), .stall_if(stall_if), .ex_valid(ex_valid), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_alu_src(ex_alu_src),
    .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne), .ex_jump(ex_jump), .ex_link(ex_link),
    .ex_alu_op(ex_alu_op), .ex_ext_op(ex_ext_op), .ex_ins_id(ex_ins_id), .ex_wr_addr(ex_wr_addr),
    .ex_md_start(ex_md_start), .md_busy(md_busy), .illegal(illegal)
  );

  pipe_ctrl_unit #(.ALUOP_W(4), .INSID_W(4), .ENABLE_MD(1'b0), .MD_LAT(MD_LAT)) dut_nomd (
    .clk(clk), .rst_n(rst_n), .ins(ins), .ins_valid(ins_valid), .ext_stall(ext_stall),
    .flush(flush), .stall_if(b_stall_if), .ex_valid(b_ex_valid), .ex_mem_write(b_ex_mem_write),
    .ex_mem_to_reg(b_ex_mem_to_reg), .ex_reg_write(b_ex_reg_write), .ex_alu_src(b_ex_alu_src),
    .ex_branch(b_ex_branch), .ex_branch_ne(b_ex_branch_ne), .ex_jump(b_ex_jump), .ex_link(b_ex_link),
    .ex_alu_op(b_ex_alu_op), .ex_ext_op(b_ex_ext_op), .ex_ins_id(b_ex_ins_id), .ex_wr_addr(b_ex_wr_addr),
    .ex_md_start(b_ex_md_start), .md_busy(b_md_busy), .illegal(b_illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  ex_t  m_ex;
  logic m_ill;
  int   cyc;
  int   mult_edge;

  function automatic ex_t bubble_ex();
    ex_t e;
    e     = '0;
    e.alu = ALU_ADD;
    return e;
  endfunction

  function automatic ex_t dut_ex();
    return {ex_valid, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_alu_src, ex_branch,
            ex_branch_ne, ex_jump, ex_link, ex_alu_op, ex_ext_op, ex_ins_id, ex_wr_addr, ex_md_start};
  endfunction

  function automatic logic model_busy();
    return (cyc - mult_edge) < MD_LAT;
  endfunction

  function automatic int classify(input logic [31:0] i);
    int k;
    k = K_BAD;
    case (i[31:26])
      6'h00: case (i[5:0])
        6'h20: k = K_ADD;  6'h22: k = K_SUB;  6'h24: k = K_AND;  6'h25: k = K_OR;
        6'h27: k = K_NOR;  6'h2A: k = K_SLT;  6'h18: k = K_MULT; 6'h10: k = K_MFHI;
        6'h12: k = K_MFLO; default: k = K_BAD;
      endcase
      6'h23: k = K_LW;   6'h2B: k = K_SW;   6'h04: k = K_BEQ;  6'h05: k = K_BNE;
      6'h02: k = K_J;    6'h03: k = K_JAL;  6'h08: k = K_ADDI; 6'h0D: k = K_ORI;
      6'h0F: k = K_LUI;
      default: k = K_BAD;
    endcase
    return k;
  endfunction

  function automatic logic uses_rs(input int k);
    return (k != K_BAD) && !(k inside {K_J, K_JAL, K_LUI, K_MFHI, K_MFLO});
  endfunction

  function automatic logic uses_rt(input int k);
    return (k inside {[K_ADD:K_SLT], K_MULT, K_SW, K_BEQ, K_BNE});
  endfunction

  function automatic ex_t expect_issue(input logic [31:0] i, input int k);
    ex_t        e;
    logic [3:0] rtab [6];
    rtab = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT};
    e       = bubble_ex();
    e.valid = 1'b1;
    if (k inside {[K_ADD:K_SLT], K_MFHI, K_MFLO}) begin e.rw = 1'b1; e.wr = i[15:11]; end
    if (k inside {K_LW, K_ADDI, K_ORI, K_LUI})    begin e.rw = 1'b1; e.wr = i[20:16]; end
    if (k == K_JAL) begin e.rw = 1'b1; e.wr = 5'd31; e.lnk = 1'b1; end
    e.m2r  = (k == K_LW);
    e.mw   = (k == K_SW);
    e.asrc = (k inside {K_LW, K_SW, K_ADDI, K_ORI, K_LUI});
    e.br   = (k inside {K_BEQ, K_BNE});
    e.bne  = (k == K_BNE);
    e.jmp  = (k inside {K_J, K_JAL});
    e.mds  = (k == K_MULT);
    if (k <= K_SLT) e.alu = rtab[k];
    else if (k inside {K_BEQ, K_BNE}) e.alu = ALU_SUB;
    else if (k == K_ORI) e.alu = ALU_OR;
    else if (k == K_LUI) e.alu = ALU_LUI;
    else e.alu = ALU_ADD;
    if (k inside {K_LW, K_SW, K_BEQ, K_BNE, K_ADDI}) e.ext = EXT_SIGN;
    else if (k == K_LUI) e.ext = EXT_UPPER;
    else e.ext = EXT_ZERO;
    case (k)
      K_LW: e.id = ID_LW;   K_SW: e.id = ID_SW;   K_BEQ: e.id = ID_BEQ; K_BNE: e.id = ID_BNE;
      K_J:  e.id = ID_J;    K_JAL: e.id = ID_JAL;
      K_ADDI, K_ORI, K_LUI: e.id = ID_IMM;
      K_MULT, K_MFHI, K_MFLO: e.id = ID_MD;
      default: e.id = ID_RTYPE;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] gen(input int k, input logic [4:0] a, input logic [4:0] b,
                                      input logic [4:0] c, input logic [15:0] imm);
    logic [5:0] fn [9];
    fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h18, 6'h10, 6'h12};
    case (k)
      K_LW:   return itype(6'h23, a, b, imm);
      K_SW:   return itype(6'h2B, a, b, imm);
      K_BEQ:  return itype(6'h04, a, b, imm);
      K_BNE:  return itype(6'h05, a, b, imm);
      K_J:    return {6'h02, a, b, imm};
      K_JAL:  return {6'h03, a, b, imm};
      K_ADDI: return itype(6'h08, a, b, imm);
      K_ORI:  return itype(6'h0D, a, b, imm);
      K_LUI:  return itype(6'h0F, a, b, imm);
      K_MULT: return rtype(a, b, 5'd0, 6'h18);
      K_MFHI: return rtype(5'd0, 5'd0, c, 6'h10);
      K_MFLO: return rtype(5'd0, 5'd0, c, 6'h12);
      default: begin
        if (k >= 0 && k <= K_SLT) return rtype(a, b, c, fn[k]);
        return imm[0] ? {6'h3F, a, b, imm} : rtype(a, b, c, 6'h01);
      end
    endcase
  endfunction

  task automatic model_reset();
    m_ex      = '0;
    m_ill     = 1'b0;
    cyc       = 0;
    mult_edge = -1000;
  endtask

  // One clock of stimulus; must be entered just after a rising edge.
  task automatic step(input logic [31:0] i, input logic v, input logic st,
                      input logic fl, output logic stl);
    int   k;
    logic lu, mdh;
    ex_t  nx;
    logic nill;
    ins = i; ins_valid = v; ext_stall = st; flush = fl;
    @(negedge clk);
    k   = classify(i);
    lu  = v && m_ex.valid && m_ex.m2r && (m_ex.wr != 5'd0) &&
          ((uses_rs(k) && (i[25:21] == m_ex.wr)) || (uses_rt(k) && (i[20:16] == m_ex.wr)));
    mdh = v && model_busy() && (k inside {K_MULT, K_MFHI, K_MFLO});
    stl = stall_if;
    check("stall_if", 64'(stall_if), 64'(st || lu || mdh));
    nill = 1'b0;
    if (fl) nx = bubble_ex();
    else if (st) begin nx = m_ex; nx.mds = 1'b0; end
    else if (lu || mdh) nx = bubble_ex();
    else if (v && k != K_BAD) begin
      nx = expect_issue(i, k);
      if (k == K_MULT) mult_edge = cyc + 1;
    end else begin
      nx   = bubble_ex();
      nill = v;
    end
    @(posedge clk);
    #1;
    cyc++;
    m_ex  = nx;
    m_ill = nill;
    check("ex_bundle", 64'(dut_ex()), 64'(m_ex));
    check("illegal", 64'(illegal), 64'(m_ill));
    check("md_busy", 64'(md_busy), 64'(model_busy()));
  endtask

  logic [31:0] w;
  logic        s;
  int          n_stall, n_busy, n_start;

  initial begin
    model_reset();
    #12;
    check("rst_bundle", 64'(dut_ex()), 64'(0));
    check("rst_md_busy", 64'(md_busy), 64'(0));
    check("rst_illegal", 64'(illegal), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Load-use: LW r8 then ADD r9,r8,r1.
    step(32'h0, 1'b0, 1'b0, 1'b0, s);
    step(itype(6'h23, 5'd1, 5'd8, 16'h0004), 1'b1, 1'b0, 1'b0, s);
    w = rtype(5'd8, 5'd1, 5'd9, 6'h20);
    step(w, 1'b1, 1'b0, 1'b0, s);
    check("lu_stall", 64'(s), 64'(1));
    check("lu_bubble", 64'(ex_valid), 64'(0));
    step(w, 1'b1, 1'b0, 1'b0, s);
    check("lu_release", 64'(s), 64'(0));
    check("lu_wr_addr", 64'(ex_wr_addr), 64'(9));
    check("lu_alu_op", 64'(ex_alu_op), 64'(ALU_ADD));

    // Load to r0 never creates a hazard.
    step(itype(6'h23, 5'd1, 5'd0, 16'h0000), 1'b1, 1'b0, 1'b0, s);
    step(rtype(5'd0, 5'd2, 5'd3, 6'h20), 1'b1, 1'b0, 1'b0, s);
    check("lw_r0_nostall", 64'(s), 64'(0));

    // MULT then MFLO, without and with an ext_stall during the wait.
    for (int rep = 0; rep < 2; rep++) begin
      step(rtype(5'd1, 5'd2, 5'd0, 6'h18), 1'b1, 1'b0, 1'b0, s);
      n_start = int'(ex_md_start);
      n_busy  = int'(md_busy);
      n_stall = 0;
      for (int t = 0; t < 20; t++) begin
        step(rtype(5'd0, 5'd0, 5'd5, 6'h12), 1'b1, (rep == 1) && (t < 2), 1'b0, s);
        if (rep == 1 && t == 0) begin
          check("md_start_hold_clr", 64'(ex_md_start), 64'(0));
          check("md_hold_valid", 64'(ex_valid), 64'(1));
        end
        n_start += int'(ex_md_start);
        n_busy  += int'(md_busy);
        if (s) n_stall++;
        else break;
      end
      check("md_stall_cycles", 64'(n_stall), 64'(MD_LAT));
      check("md_busy_cycles", 64'(n_busy), 64'(MD_LAT));
      check("md_start_pulses", 64'(n_start), 64'(1));
      check("mflo_issue", 64'({ex_valid, ex_wr_addr}), 64'({1'b1, 5'd5}));
    end

    // Flush wins over ext_stall with BEQ in EX.
    step(itype(6'h04, 5'd1, 5'd2, 16'h0010), 1'b1, 1'b0, 1'b0, s);
    check("beq_branch", 64'(ex_branch), 64'(1));
    step(rtype(5'd1, 5'd2, 5'd3, 6'h20), 1'b1, 1'b1, 1'b1, s);
    check("flush_valid", 64'(ex_valid), 64'(0));
    check("flush_branch", 64'(ex_branch), 64'(0));

    // JAL.
    step(32'h0C000010, 1'b1, 1'b0, 1'b0, s);
    check("jal_bits", 64'({ex_jump, ex_link, ex_reg_write, ex_wr_addr}), 64'({3'b111, 5'd31}));

    // Unknown opcode 0x3F.
    step(32'hFC000000, 1'b1, 1'b0, 1'b0, s);
    check("bad_illegal", 64'(illegal), 64'(1));
    check("bad_valid", 64'(ex_valid), 64'(0));
    check("bad_nostall", 64'(s), 64'(0));
    step(32'h0, 1'b0, 1'b0, 1'b0, s);
    check("bad_pulse_end", 64'(illegal), 64'(0));

    // ENABLE_MD=0 instance rejects MULT.
    step(rtype(5'd1, 5'd2, 5'd0, 6'h18), 1'b1, 1'b0, 1'b0, s);
    check("nomd_illegal", 64'(b_illegal), 64'(1));
    check("nomd_valid", 64'(b_ex_valid), 64'(0));
    step(32'h0, 1'b0, 1'b0, 1'b0, s);
    check("nomd_pulse_end", 64'(b_illegal), 64'(0));

    // Asynchronous reset while MULT is busy.
    step(rtype(5'd3, 5'd2, 5'd0, 6'h18), 1'b1, 1'b0, 1'b0, s);
    step(32'h0, 1'b0, 1'b0, 1'b0, s);
    check("pre_rst_busy", 64'(md_busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("arst_bundle", 64'(dut_ex()), 64'(0));
    check("arst_md_busy", 64'(md_busy), 64'(0));
    check("arst_stall", 64'(stall_if), 64'(0));
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    step(rtype(5'd0, 5'd0, 5'd4, 6'h10), 1'b1, 1'b0, 1'b0, s);
    check("post_rst_mfhi", 64'({s, ex_valid}), 64'({1'b0, 1'b1}));

    // Randomized stream.
    for (int n = 0; n < 600; n++) begin
      w = gen(int'($urandom_range(0, 18)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 16'($urandom));
      step(w, ($urandom_range(0, 9) != 0), ($urandom_range(0, 6) == 0),
           ($urandom_range(0, 11) == 0), s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Registered decode/control stage for the pipelined MIPS core, sitting between the IF/ID and ID/EX registers.
- Decodes the ID-stage instruction and registers the full control bundle into EX.
- Detects load-use and multiply-busy hazards, inserting bubbles and holding IF/ID.
- Honours external stall and branch flush.
- Supports an extended instruction set and an optional multi-cycle MULT unit with HI/LO reads.

Parameters:
ALUOP_W, 4, width of ALU opcode field
INSID_W, 4, width of instruction-class field
ENABLE_MD, 1, 1 = MULT/MFHI/MFLO legal; 0 = treated as illegal
MD_LAT, 4, MULT busy cycles after issue (1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ins  in  32  instruction in ID
ins_valid  in  1  ID holds a real instruction
ext_stall  in  1  memory stall; hold everything
flush  in  1  branch/jump resolved taken; kill EX entry
stall_if  out  1  combinational; hold PC and IF/ID
ex_valid  out  1  EX entry is a real instruction
ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_alu_src, ex_branch, ex_branch_ne, ex_jump, ex_link  out  1 each  control bits
ex_alu_op  out  ALUOP_W  ALU operation
ex_ext_op  out  2  0 zero-ext, 1 sign-ext, 2 upper (lui)
ex_ins_id  out  INSID_W  instruction class
ex_wr_addr  out  5  destination register (0 if none)
ex_md_start  out  1  one-cycle MULT start to EX
md_busy  out  1  MULT counter non-zero
illegal  out  1  registered one-cycle pulse, unknown encoding issued

Behaviour:
- Reset (async, rst_n=0): every registered output 0, ex_alu_op = ADD, md counter 0, illegal 0.
- Decode set:
  - R-type funct: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, NOR 0x27, SLT 0x2A, MULT 0x18, MFHI 0x10, MFLO 0x12.
  - Opcodes: LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, J 0x02, JAL 0x03, ADDI 0x08, ORI 0x0D, LUI 0x0F.
- Destination register (ex_wr_addr):
  - rd for R-type ALU ops and MFHI/MFLO.
  - rt for LW, ADDI, ORI, LUI.
  - 31 for JAL (ex_link=1).
  - 0 with ex_reg_write=0 otherwise.
- Source use:
  - rs is used by all except J, JAL, LUI, MFHI, MFLO.
  - rt is used by R-type ALU ops, MULT, SW, BEQ, BNE.
- Hazards (combinational, ins_valid=1):
  - load_use = ex_valid & ex_mem_to_reg & ex_wr_addr!=0 & ex_wr_addr matches a used source.
  - md_haz = md_busy & (MFHI|MFLO|MULT).
- stall_if = ext_stall | load_use | md_haz.
- Next-edge priority:
  1. flush: EX becomes bubble (all controls 0, ex_valid 0).
  2. ext_stall: EX register holds its value.
  3. load_use or md_haz: insert a bubble.
  4. Otherwise issue the decoded bundle; ex_valid = ins_valid.
- Unknown encoding with ins_valid: issue a bubble, pulse illegal for one cycle; no stall.
- MD counter:
  - Loaded with MD_LAT when MULT issues (same edge ex_md_start=1).
  - Otherwise decrements each cycle while non-zero, including during ext_stall and flush.
  - Flush does not cancel an issued MULT.
- md_busy = counter != 0.
- ex_md_start is 1 only for the cycle after issue; it is cleared under ext_stall hold as well.
- Reset mid-operation: counter and EX register clear immediately; no pending stall.

Decomposition:
- Shared include ctrl_encode_def extended with:
  - ALUOP codes: ADD, SUB, AND, OR, NOR, SLT, LUI.
  - EXTOP codes.
  - INS_ID classes: RTYPE, LW, SW, BEQ, BNE, J, JAL, IMM, MD.
- Shared include instruction_def extended with the new opcode/funct values.
- One sub-module: ctrl_decode (purely combinational ins -> bundle + used-source flags + illegal). The top module holds hazard logic, EX register and MD counter.

Test Plan:
- Reset: assert rst_n=0 mid-run with MULT busy -> all outputs 0, md_busy=0 asynchronously.
- Load-use: LW r8 issued, next ins ADD r9,r8,r1 -> stall_if=1 for exactly 1 cycle, EX bubble, then ADD issues with ex_wr_addr=9, ex_alu_op=ADD.
- LW to r0 followed by ADD using r0 -> no stall.
- MULT then MFLO with MD_LAT=4:
  - ex_md_start pulses once, md_busy for 4 cycles.
  - MFLO stalled 4 cycles, issues on the 5th.
  - Repeat with ext_stall during the wait: count unchanged.
- Flush and ext_stall asserted together while BEQ sits in EX -> EX cleared (ex_valid=0), not held.
- JAL 0x0C000010 -> ex_jump=1, ex_link=1, ex_reg_write=1, ex_wr_addr=31.
- Opcode 0x3F -> illegal pulse 1 cycle, ex_valid=0.
- ENABLE_MD=0: MULT -> illegal pulse 1 cycle.
